// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master)
// and instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// RV32I fetch/next-PC controller: owns the PC, runs the imem handshake and
// retires one instruction at a time. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pc_sequencer_if.master       imem,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  output logic                 instr_valid,
  output logic                 retire,
  input  logic                 stall,
  input  logic                 is_branch,
  input  logic                 br_taken,
  input  logic                 is_jal,
  input  logic                 is_jalr,
  input  logic [31:0]          br_target,
  input  logic [31:0]          jal_target,
  input  logic [31:0]          jalr_target,
  input  logic                 halt,
  output logic                 halted,
  output logic                 fetch_err,
  output logic                 misalign_err
);

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT,
    ERR
  } state_t;

  state_t      state;
  logic [7:0]  timeout_cnt;
  logic        req_q;
  logic [31:0] sel_target;
  logic [31:0] next_pc;
  logic        unused_sel_bits;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  // Commit happens in the same cycle the datapath sees the instruction unstalled,
  // so writeback still observes the PC of the retiring instruction.
  assign retire = instr_valid & ~stall;

  always_comb begin
    sel_target = pc + 32'd4;
    if (is_jalr)
      sel_target = {jalr_target[31:1], 1'b0};
    else if (is_jal)
      sel_target = jal_target;
    else if (is_branch && br_taken)
      sel_target = br_target;
  end

  assign next_pc         = {sel_target[31:2], 2'b00};
  assign unused_sel_bits = ^{sel_target[1:0], jalr_target[0]};

`ifndef PC_MISALIGN_TRAP_EN
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      timeout_cnt <= 8'd0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            timeout_cnt <= 8'd0;
            req_q       <= 1'b0;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            req_q     <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            // halt outranks any jump: the PC of the EBREAK is preserved
            if (halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end
`ifdef PC_MISALIGN_TRAP_EN
            else if (sel_target[1]) begin
              halted       <= 1'b1;
              misalign_err <= 1'b1;
              state        <= HALT;
            end
`endif
            else begin
              pc    <= next_pc;
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end
        HALT, ERR: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        retire;
  logic        stall;
  logic        is_branch;
  logic        br_taken;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] br_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic        halt;
  logic        halted;
  logic        fetch_err;
  logic        misalign_err;

  int checkCount = 0;
  int passCount  = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem         (bus.master),
    .instr        (instr),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .retire       (retire),
    .stall        (stall),
    .is_branch    (is_branch),
    .br_taken     (br_taken),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .br_target    (br_target),
    .jal_target   (jal_target),
    .jalr_target  (jalr_target),
    .halt         (halt),
    .halted       (halted),
    .fetch_err    (fetch_err),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic t, input logic j,
                               input logic jr, input logic h, input logic [31:0] bt,
                               input logic [31:0] jt, input logic [31:0] jrt);
    stall       = s;
    is_branch   = b;
    br_taken    = t;
    is_jal      = j;
    is_jalr     = jr;
    halt        = h;
    br_target   = bt;
    jal_target  = jt;
    jalr_target = jrt;
  endtask

  task automatic clearStimulus();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic resetPulse();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for a request, acks it immediately and lands in EXEC
  task automatic doFetch(input string tag, input logic [31:0] word);
    for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
    checkOutput({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack = 1'b0;
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_instr"}, instr, word);
  endtask

  task automatic retireTo(input string tag, input logic [31:0] expAddr);
    #1;
    checkOutput({tag, "_retire"}, 32'(retire), 32'd1);
    tick();
    checkOutput({tag, "_addr"}, bus.imem_addr, expAddr);
    checkOutput({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    clearStimulus();
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    clearStimulus();
    tick();
    tick();

    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_retire", 32'(retire), 32'd0);
    checkOutput("rst_flags", {29'd0, halted, fetch_err, misalign_err}, 32'd0);

    // First instruction: IDLE, FETCH with immediate ack, EXEC
    reset_n = 1'b1;
    tick();
    checkOutput("first_req", 32'(bus.imem_req), 32'd1);
    checkOutput("first_addr", bus.imem_addr, 32'h0);
    checkOutput("first_notvalid", 32'(instr_valid), 32'd0);
    doFetch("first", 32'h0000_0013);
    checkOutput("first_req_low", 32'(bus.imem_req), 32'd0);
    retireTo("first", 32'h4);

    // Stall holds instruction and PC; exactly one retire
    doFetch("stall", 32'h0010_0093);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_retire", 32'(retire), 32'd0);
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
      checkOutput("stall_pc", pc, 32'h4);
      tick();
    end
    stall = 1'b0;
    checkOutput("stall_instr", instr, 32'h0010_0093);
    retireTo("stall", 32'h8);

    doFetch("seq8", 32'h0000_0013);
    retireTo("seq8", 32'hC);
    doFetch("seqc", 32'h0000_0013);
    retireTo("seqc", 32'h10);

    // Branch not taken at 0x10, JALR back to 0x10 (bit0 cleared), then taken
    doFetch("bnt", 32'h0000_0063);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
    retireTo("bnt", 32'h14);
    doFetch("jalr", 32'h0000_0067);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h11);
    retireTo("jalr", 32'h10);
    doFetch("btk", 32'h0000_0063);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
    retireTo("btk", 32'h40);

    // JALR outranks JAL
    doFetch("prio", 32'h0000_0067);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h200, 32'h101);
    retireTo("prio", 32'h100);

    // Sequential wrap at the top of the address space
    doFetch("wrapj", 32'h0000_0067);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    retireTo("wrapj", 32'hFFFF_FFFC);
    doFetch("wrap", 32'h0000_0013);
    retireTo("wrap", 32'h0);

    // Halt together with a jump: retire, PC kept, sticky halted
    doFetch("halt", 32'h0010_0073);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h80, 32'h0);
    #1;
    checkOutput("halt_retire", 32'(retire), 32'd1);
    tick();
    clearStimulus();
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_pc", pc, 32'h0);
    checkOutput("halt_req", 32'(bus.imem_req), 32'd0);
    checkOutput("halt_valid", 32'(instr_valid), 32'd0);
    bus.imem_ack = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    checkOutput("halt_sticky", 32'(halted), 32'd1);
    checkOutput("halt_stay_valid", 32'(instr_valid), 32'd0);
    resetPulse();
    checkOutput("halt_rst", 32'(halted), 32'd0);

    // Misaligned JAL target
    tick();
    doFetch("mis", 32'h0000_006F);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h22, 32'h0);
    #1;
    checkOutput("mis_retire", 32'(retire), 32'd1);
    tick();
    clearStimulus();
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("mis_err", 32'(misalign_err), 32'd1);
    checkOutput("mis_halted", 32'(halted), 32'd1);
    checkOutput("mis_pc", pc, 32'h0);
`else
    checkOutput("mis_err", 32'(misalign_err), 32'd0);
    checkOutput("mis_halted", 32'(halted), 32'd0);
    checkOutput("mis_pc", pc, 32'h20);
`endif

    // Asynchronous reset in the middle of EXEC aborts without a retire
    resetPulse();
    tick();
    doFetch("abort", 32'h0000_0013);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(instr_valid), 32'd0);
    checkOutput("abort_retire", 32'(retire), 32'd0);
    checkOutput("abort_pc", pc, 32'h0);
    tick();
    reset_n = 1'b1;

    // Fetch timeout: 16 FETCH cycles without ack
    tick();
    checkOutput("to_req_start", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("to_req_15", 32'(bus.imem_req), 32'd1);
    checkOutput("to_err_15", 32'(fetch_err), 32'd0);
    tick();
    checkOutput("to_err_16", 32'(fetch_err), 32'd1);
    checkOutput("to_req_16", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    checkOutput("to_err_sticky", 32'(fetch_err), 32'd1);
    checkOutput("to_valid", 32'(instr_valid), 32'd0);
    resetPulse();
    checkOutput("to_err_rst", 32'(fetch_err), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
